// File: rtl/dcache_read_arbiter_pkg.sv
// Shared definitions for the dcache read-port arbiter: FSM encoding, port ids and default widths.
package dcache_read_arbiter_pkg;

  localparam int ARB_ADDR_W = 32;
  localparam int ARB_DATA_W = 64;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_REQ  = 2'b01,
    ST_RESP = 2'b10
  } arb_state_e;

  localparam logic PORT_OPFETCH = 1'b0;
  localparam logic PORT_AUX     = 1'b1;

  // One-hot grant vector for a single port id.
  function automatic logic [1:0] port_onehot(input logic port);
    return port ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/dcache_read_arb_pick.sv
// Combinational winner select between the two read requesters; the pointer names the
// port that wins when both are valid.
module dcache_read_arb_pick
  import dcache_read_arbiter_pkg::*;
(
  input  logic [1:0] req_valid_i,
  input  logic       ptr_i,
  output logic [1:0] gnt_o
);

  // Single requester wins outright; contention is resolved by the pointer.
  always_comb begin
    gnt_o = 2'b00;
    case (req_valid_i)
      2'b01:   gnt_o = port_onehot(PORT_OPFETCH);
      2'b10:   gnt_o = port_onehot(PORT_AUX);
      2'b11:   gnt_o = port_onehot(ptr_i);
      default: gnt_o = 2'b00;
    endcase
  end

endmodule

// File: rtl/dcache_read_arbiter.sv
// Two-requester arbiter for the single dcache read port, one transaction outstanding.
// Define DCACHE_READ_ARB_RR_EN for round-robin; otherwise port 0 has fixed priority.
module dcache_read_arbiter
  import dcache_read_arbiter_pkg::*;
#(
  parameter int ADDR_W = ARB_ADDR_W,
  parameter int DATA_W = ARB_DATA_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req0_valid,
  input  logic              req1_valid,
  output logic              req0_ready,
  output logic              req1_ready,
  input  logic [ADDR_W-1:0] req0_address,
  input  logic [ADDR_W-1:0] req1_address,
  output logic              rsp0_valid,
  output logic              rsp1_valid,
  input  logic              rsp0_ready,
  input  logic              rsp1_ready,
  output logic [DATA_W-1:0] rsp_data,
  output logic              rd_req_valid,
  input  logic              rd_req_ready,
  output logic [ADDR_W-1:0] rd_req_address,
  input  logic              rd_dp_valid,
  output logic              rd_dp_ready,
  input  logic [DATA_W-1:0] rd_dp_read_data,
  output logic              busy
);

  arb_state_e        state_q, state_d;
  logic              owner_q, owner_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              ptr_s;
  logic [1:0]        gnt_s;
  logic              rd_dp_ready_s;

`ifdef DCACHE_READ_ARB_RR_EN
  logic ptr_q, ptr_d;

  // Pointer moves to the non-owner only when a response completes.
  always_comb begin
    if ((state_q == ST_RESP) && rd_dp_valid && rd_dp_ready_s) begin
      ptr_d = ~owner_q;
    end else begin
      ptr_d = ptr_q;
    end
  end

  // Round-robin pointer register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ptr_q <= PORT_OPFETCH;
    end else begin
      ptr_q <= ptr_d;
    end
  end

  assign ptr_s = ptr_q;
`else
  assign ptr_s = PORT_OPFETCH;
`endif

  dcache_read_arb_pick u_pick (
    .req_valid_i ({req1_valid, req0_valid}),
    .ptr_i       (ptr_s),
    .gnt_o       (gnt_s)
  );

  // Next-state and handshake muxing; readys are also gated by reset so nothing is
  // accepted while reset is held.
  always_comb begin
    state_d       = state_q;
    owner_d       = owner_q;
    addr_d        = addr_q;
    req0_ready    = 1'b0;
    req1_ready    = 1'b0;
    rsp0_valid    = 1'b0;
    rsp1_valid    = 1'b0;
    rd_req_valid  = 1'b0;
    rd_dp_ready_s = 1'b0;
    case (state_q)
      ST_IDLE: begin
        req0_ready = gnt_s[0] & reset;
        req1_ready = gnt_s[1] & reset;
        if (gnt_s != 2'b00) begin
          state_d = ST_REQ;
          owner_d = gnt_s[1];
          addr_d  = gnt_s[1] ? req1_address : req0_address;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_REQ: begin
        rd_req_valid = 1'b1;
        if (rd_req_ready) begin
          state_d = ST_RESP;
        end else begin
          state_d = ST_REQ;
        end
      end
      ST_RESP: begin
        rd_dp_ready_s = owner_q ? rsp1_ready : rsp0_ready;
        rsp0_valid    = rd_dp_valid & ~owner_q;
        rsp1_valid    = rd_dp_valid & owner_q;
        if (rd_dp_valid && rd_dp_ready_s) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_RESP;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State, owner and latched address registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      owner_q <= PORT_OPFETCH;
      addr_q  <= {ADDR_W{1'b0}};
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      addr_q  <= addr_d;
    end
  end

  assign rd_dp_ready    = rd_dp_ready_s;
  assign rd_req_address = addr_q;
  assign rsp_data       = rd_dp_read_data;
  assign busy           = (state_q != ST_IDLE);

endmodule

// File: tb/tb_dcache_read_arbiter.sv
// Self-checking bench for dcache_read_arbiter: table vectors, directed corner cases and
// randomized traffic against a transaction-level reference model.
module tb_dcache_read_arbiter;

`ifdef DCACHE_READ_ARB_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic        clk;
  logic        reset;
  logic        req0_valid, req1_valid;
  logic        req0_ready, req1_ready;
  logic [31:0] req0_address, req1_address;
  logic        rsp0_valid, rsp1_valid;
  logic        rsp0_ready, rsp1_ready;
  logic [63:0] rsp_data;
  logic        rd_req_valid, rd_req_ready;
  logic [31:0] rd_req_address;
  logic        rd_dp_valid, rd_dp_ready;
  logic [63:0] rd_dp_read_data;
  logic        busy;

  int checks = 0;
  int errors = 0;

  // Reference model: one outstanding transaction, issued or not, plus the contention pointer.
  bit          m_pend, m_iss, m_own, m_ptr;
  logic [31:0] m_addr;
  bit          e_r0, e_r1, e_rdv, e_dpr;

  typedef struct {
    logic v0;
    logic v1;
    logic e0;
    logic e1;
  } vec_t;
  vec_t tbl[4];

  dcache_read_arbiter dut (
    .clk             (clk),
    .reset           (reset),
    .req0_valid      (req0_valid),
    .req1_valid      (req1_valid),
    .req0_ready      (req0_ready),
    .req1_ready      (req1_ready),
    .req0_address    (req0_address),
    .req1_address    (req1_address),
    .rsp0_valid      (rsp0_valid),
    .rsp1_valid      (rsp1_valid),
    .rsp0_ready      (rsp0_ready),
    .rsp1_ready      (rsp1_ready),
    .rsp_data        (rsp_data),
    .rd_req_valid    (rd_req_valid),
    .rd_req_ready    (rd_req_ready),
    .rd_req_address  (rd_req_address),
    .rd_dp_valid     (rd_dp_valid),
    .rd_dp_ready     (rd_dp_ready),
    .rd_dp_read_data (rd_dp_read_data),
    .busy            (busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  task automatic model_reset();
    m_pend = 1'b0;
    m_iss  = 1'b0;
    m_own  = 1'b0;
    m_ptr  = 1'b0;
    m_addr = 32'h0;
  endtask

  task automatic model_eval();
    bit win;
    win   = RR ? m_ptr : 1'b0;
    e_r0  = reset && !m_pend && req0_valid && (!req1_valid || !win);
    e_r1  = reset && !m_pend && req1_valid && (!req0_valid || win);
    e_rdv = m_pend && !m_iss;
    e_dpr = m_iss && (m_own ? rsp1_ready : rsp0_ready);
  endtask

  // Inputs are driven at edge+1; outputs compared at edge+4.
  task automatic settle_check();
    #3;
    model_eval();
    chk("m_req_ready", 64'({req1_ready, req0_ready}), 64'({e_r1, e_r0}));
    chk("m_rd_req_valid", 64'(rd_req_valid), 64'(e_rdv));
    chk("m_rd_req_address", 64'(rd_req_address), 64'(m_addr));
    chk("m_rsp_valid", 64'({rsp1_valid, rsp0_valid}),
        64'({m_iss && rd_dp_valid && m_own, m_iss && rd_dp_valid && !m_own}));
    chk("m_rd_dp_ready", 64'(rd_dp_ready), 64'(e_dpr));
    chk("m_rsp_data", rsp_data, rd_dp_read_data);
    chk("m_busy", 64'(busy), 64'(m_pend));
  endtask

  task automatic advance();
    model_eval();
    @(posedge clk);
    if (!reset) begin
      model_reset();
    end else if (e_r0) begin
      m_pend = 1'b1; m_iss = 1'b0; m_own = 1'b0; m_addr = req0_address;
    end else if (e_r1) begin
      m_pend = 1'b1; m_iss = 1'b0; m_own = 1'b1; m_addr = req1_address;
    end else if (e_rdv && rd_req_ready) begin
      m_iss = 1'b1;
    end else if (e_dpr && rd_dp_valid) begin
      m_pend = 1'b0; m_iss = 1'b0; m_ptr = !m_own;
    end
    #1;
  endtask

  task automatic clear_inputs();
    req0_valid = 1'b0; req1_valid = 1'b0;
    req0_address = 32'h0; req1_address = 32'h0;
    rsp0_ready = 1'b0; rsp1_ready = 1'b0;
    rd_req_ready = 1'b0; rd_dp_valid = 1'b0; rd_dp_read_data = 64'h0;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    clear_inputs();
    model_reset();
    settle_check();
    advance();
    reset = 1'b1;
  endtask

  initial begin
    int n_acc;
    int n_issue;
    logic owners[4];

    tbl[0] = '{v0: 1'b0, v1: 1'b0, e0: 1'b0, e1: 1'b0};
    tbl[1] = '{v0: 1'b1, v1: 1'b0, e0: 1'b1, e1: 1'b0};
    tbl[2] = '{v0: 1'b0, v1: 1'b1, e0: 1'b0, e1: 1'b1};
    tbl[3] = '{v0: 1'b1, v1: 1'b1, e0: 1'b1, e1: 1'b0};

    reset = 1'b0;
    clear_inputs();
    model_reset();
    @(posedge clk);
    #1;

    // Reset state: everything idle, requests ignored while reset is low.
    req0_valid = 1'b1; req1_valid = 1'b1;
    settle_check();
    chk("rst_req_ready", 64'({req1_ready, req0_ready}), 64'(2'b00));
    chk("rst_busy", 64'(busy), 64'(0));
    chk("rst_rd_req_valid", 64'(rd_req_valid), 64'(0));
    chk("rst_rd_req_address", 64'(rd_req_address), 64'(0));
    chk("rst_rd_dp_ready", 64'(rd_dp_ready), 64'(0));
    advance();

    // Picker vectors from IDLE with a fresh pointer.
    do_reset();
    for (int i = 0; i < 4; i++) begin
      req0_valid = tbl[i].v0;
      req1_valid = tbl[i].v1;
      settle_check();
      chk("tbl_ready", 64'({req1_ready, req0_ready}), 64'({tbl[i].e1, tbl[i].e0}));
      req0_valid = 1'b0;
      req1_valid = 1'b0;
      advance();
    end

    // Single port 0 read with an immediately ready dcache.
    do_reset();
    req0_valid = 1'b1; req0_address = 32'h0000_1000;
    settle_check();
    chk("t1_c0_req0_ready", 64'(req0_ready), 64'(1));
    advance();
    req0_valid = 1'b0; rd_req_ready = 1'b1;
    settle_check();
    chk("t1_c1_rd_req_valid", 64'(rd_req_valid), 64'(1));
    chk("t1_c1_rd_req_address", 64'(rd_req_address), 64'(32'h0000_1000));
    advance();
    rd_req_ready = 1'b0; rd_dp_valid = 1'b1; rsp0_ready = 1'b1;
    rd_dp_read_data = 64'h1122_3344_5566_7788;
    settle_check();
    chk("t1_c2_rsp0_valid", 64'(rsp0_valid), 64'(1));
    chk("t1_c2_rsp1_valid", 64'(rsp1_valid), 64'(0));
    chk("t1_c2_rsp_data", rsp_data, 64'h1122_3344_5566_7788);
    advance();
    rd_dp_valid = 1'b0;
    settle_check();
    chk("t1_c3_busy", 64'(busy), 64'(0));
    advance();

    // Continuous contention: four transactions, three cycles each.
    do_reset();
    req0_valid = 1'b1; req1_valid = 1'b1;
    req0_address = 32'h0000_0100; req1_address = 32'h0000_0200;
    rd_req_ready = 1'b1; rd_dp_valid = 1'b1; rsp0_ready = 1'b1; rsp1_ready = 1'b1;
    n_acc = 0;
    for (int c = 0; c < 12; c++) begin
      settle_check();
      if (req0_ready || req1_ready) begin
        if (n_acc < 4) owners[n_acc] = req1_ready;
        n_acc++;
      end
      advance();
    end
    chk("cont_accept_count", 64'(n_acc), 64'(4));
    for (int i = 0; i < 4; i++) begin
      chk("cont_owner", 64'(owners[i]), 64'(RR ? (i % 2) : 0));
    end

    // Port 1 transaction with dcache request stall then response stall.
    do_reset();
    req1_valid = 1'b1; req1_address = 32'hDEAD_BEEC;
    settle_check();
    chk("st_req1_ready", 64'(req1_ready), 64'(1));
    advance();
    req0_valid = 1'b1; req0_address = 32'h0000_5550;
    for (int c = 0; c < 5; c++) begin
      settle_check();
      chk("st_rd_req_valid", 64'(rd_req_valid), 64'(1));
      chk("st_rd_req_address", 64'(rd_req_address), 64'(32'hDEAD_BEEC));
      chk("st_req_ready", 64'({req1_ready, req0_ready}), 64'(2'b00));
      advance();
    end
    rd_req_ready = 1'b1;
    settle_check();
    advance();
    req0_valid = 1'b0; req1_valid = 1'b0; rd_req_ready = 1'b0;
    rd_dp_valid = 1'b1; rd_dp_read_data = 64'hCAFE_F00D_0BAD_BEEF;
    rsp0_ready = 1'b1; rsp1_ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      settle_check();
      chk("st_rd_dp_ready", 64'(rd_dp_ready), 64'(0));
      chk("st_rsp1_valid", 64'(rsp1_valid), 64'(1));
      chk("st_rsp0_valid", 64'(rsp0_valid), 64'(0));
      chk("st_busy", 64'(busy), 64'(1));
      advance();
    end
    rsp1_ready = 1'b1;
    settle_check();
    chk("st_done_rd_dp_ready", 64'(rd_dp_ready), 64'(1));
    advance();
    rd_dp_valid = 1'b0;
    settle_check();
    chk("st_idle_busy", 64'(busy), 64'(0));
    advance();

    // Reset asserted while in RESP.
    do_reset();
    req0_valid = 1'b1; req0_address = 32'h0000_2000;
    settle_check();
    advance();
    req0_valid = 1'b0; rd_req_ready = 1'b1;
    settle_check();
    advance();
    rd_req_ready = 1'b0; rd_dp_valid = 1'b1; rsp0_ready = 1'b1;
    #1;
    chk("rr_pre_rd_dp_ready", 64'(rd_dp_ready), 64'(1));
    reset = 1'b0;
    model_reset();
    #1;
    chk("rr_rd_dp_ready", 64'(rd_dp_ready), 64'(0));
    chk("rr_rsp_valid", 64'({rsp1_valid, rsp0_valid}), 64'(2'b00));
    chk("rr_busy", 64'(busy), 64'(0));
    @(posedge clk);
    #1;
    rd_dp_valid = 1'b0;
    settle_check();
    advance();
    reset = 1'b1;
    req0_valid = 1'b1; req1_valid = 1'b1;
    settle_check();
    chk("rr_after_grant", 64'({req1_ready, req0_ready}), 64'(2'b01));
    advance();

    // Port 1 pulse during a port 0 RESP is ignored.
    do_reset();
    req0_valid = 1'b1; req0_address = 32'h0000_3000;
    settle_check();
    advance();
    req0_valid = 1'b0; rd_req_ready = 1'b1;
    settle_check();
    advance();
    rd_req_ready = 1'b0; req1_valid = 1'b1; req1_address = 32'h0000_4000;
    settle_check();
    chk("pulse_req1_ready", 64'(req1_ready), 64'(0));
    advance();
    req1_valid = 1'b0; rd_dp_valid = 1'b1; rsp0_ready = 1'b1;
    settle_check();
    chk("pulse_rsp0_valid", 64'(rsp0_valid), 64'(1));
    advance();
    rd_dp_valid = 1'b0;
    n_issue = 0;
    for (int c = 0; c < 3; c++) begin
      settle_check();
      if (rd_req_valid) n_issue++;
      advance();
    end
    chk("pulse_no_second_req", 64'(n_issue), 64'(0));

    // Randomized traffic against the model, with occasional reset pulses.
    do_reset();
    for (int c = 0; c < 500; c++) begin
      reset           = ($urandom_range(0, 63) != 0);
      req0_valid      = 1'($urandom_range(0, 1));
      req1_valid      = 1'($urandom_range(0, 1));
      req0_address    = $urandom;
      req1_address    = $urandom;
      rd_req_ready    = ($urandom_range(0, 3) != 0);
      rd_dp_valid     = ($urandom_range(0, 2) != 0);
      rsp0_ready      = ($urandom_range(0, 3) != 0);
      rsp1_ready      = ($urandom_range(0, 3) != 0);
      rd_dp_read_data = {$urandom, $urandom};
      if (!reset) model_reset();
      settle_check();
      advance();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/dcache_read_arbiter.md
# dcache_read_arbiter

Shares the single data-cache read port between two requesters: port 0 is the memory-read stage operand fetch, port 1 is the secondary reader (stack/string micro-op reads). It accepts one request at a time, drives the dcache request/data-phase handshake, and routes the returned 64-bit data back to the requester that owns the transaction. It sits between the memory-read stage and the dcache read interface, with at most one transaction outstanding.

## Interface
- ADDR_W, 32, request address width
- DATA_W, 64, read data width
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low reset
- req0_valid / req1_valid  in  1  requester N has an address to read
- req0_ready / req1_ready  out  1  requester N's address accepted this cycle
- req0_address / req1_address  in  ADDR_W  read address from requester N
- rsp0_valid / rsp1_valid  out  1  read data for requester N valid
- rsp0_ready / rsp1_ready  in  1  requester N can take data
- rsp_data  out  DATA_W  read data, shared by both response ports
- rd_req_valid  out  1  request to dcache
- rd_req_ready  in  1  dcache accepts request
- rd_req_address  out  ADDR_W  registered address to dcache
- rd_dp_valid  in  1  dcache data phase valid
- rd_dp_ready  out  1  arbiter accepts data phase
- rd_dp_read_data  in  DATA_W  dcache read data
- busy  out  1  transaction in flight (state != IDLE)

## Operation
- States: IDLE, REQ, RESP; 2-bit registered state, owner bit, ADDR_W address register, priority pointer.
- IDLE: if any reqN_valid, the picker selects a winner; only the winner's reqN_ready is 1 (combinational). On acceptance: latch the address and owner, then go to REQ. Other ready is 0. If there is no request, stay in IDLE.
- REQ: rd_req_valid=1, rd_req_address=latched address (stable until accepted). On rd_req_ready=1, go to RESP.
- RESP: rd_dp_ready = rsp[owner]_ready. rsp[owner]_valid = rd_dp_valid, and the non-owner rsp_valid is 0. rsp_data = rd_dp_read_data (pass-through). On rd_dp_valid & rd_dp_ready, go to IDLE and update the priority pointer.
- Priority pointer: holds the port that is not the last completed owner; updated only on response completion.
- Simultaneous req0_valid & req1_valid in IDLE: the winner is set by the pointer (see Configuration).
- A requester deasserting valid in IDLE before acceptance is legal; nothing is latched.
- No new request is accepted in REQ or RESP (both readys are 0), and there is no back-to-back acceptance in the completing cycle.
- Reset: async, takes effect immediately mid-transaction. State=IDLE, owner=0, pointer=port 0, address=0. Any in-flight dcache transaction is abandoned. All outputs are 0: req*_ready, rsp*_valid, rd_req_valid, rd_dp_ready, busy, rd_req_address, rsp_data follows input.

## Timing
- Cycle 0: req accepted (valid & ready, IDLE).
- Cycle 1: rd_req_valid=1 (registered).
- Earliest rsp: cycle 2 if rd_req_ready in cycle 1 and rd_dp_valid in cycle 2.
- Next acceptance: the cycle after the response handshake, giving a minimum of 3 cycles per transaction.
- rd_req_ready and rsp_ready stalls extend REQ and RESP indefinitely, with outputs held.

## Configuration
- DCACHE_READ_ARB_RR_EN defined: round-robin. The pointer flips to the non-owner after each completion, so a contending port wins at most every other transaction.
- Undefined: fixed priority, port 0 always wins on contention. The pointer register is omitted and port 1 is served only when req0_valid=0.

## Structure
- Shared package: state encodings (IDLE=2'b00, REQ=2'b01, RESP=2'b10), port id constants (PORT_OPFETCH=0, PORT_AUX=1), and ADDR_W/DATA_W defaults.
- One sub-module, dcache_read_arb_pick: combinational winner select from {req1_valid, req0_valid, pointer}, giving a grant one-hot.
- The top holds the state, owner, address and pointer registers, plus the handshake muxing.

## Test plan
- Single port 0 read at 0x0000_1000, dcache ready immediately, data 0x1122334455667788 -> rd_req_valid cycle 1, rsp0_valid cycle 2 with that data, rsp1_valid never set.
- Both valid in cycle 0, continuously, 4 transactions with RR_EN -> owners 0,1,0,1. Without RR_EN -> owners 0,0,0,0.
- rd_req_ready held low for 5 cycles -> rd_req_valid=1 and rd_req_address constant throughout, both req*_ready=0.
- rd_dp_valid=1 with rsp1_ready=0 for 3 cycles (owner 1) -> rd_dp_ready=0, rsp1_valid=1 and state stays RESP. Completes in the cycle rsp1_ready=1, and IDLE follows.
- reset asserted low in RESP -> same-cycle rd_dp_ready=0, rsp*_valid=0, busy=0. After release, simultaneous requests grant port 0.
- req1_valid pulses for one cycle during RESP of a port 0 transaction -> not accepted, req1_ready=0, no second dcache request issued.
